// File: rtl/flash_voice3.sv
// ---------------------------------------------------------------------------
// flash_voice3
// Three-voice sample-playback sequencer sitting on both sides of flashspi.
// Each voice walks a flash region with an 8.8 fixed-point phase increment,
// optionally looping, and the three fetched samples are presented together
// once per sample period.
//
// Ports
//   i_clk, i_reset        system clock, asynchronous active-high reset
//   i_samp_ena            one-cycle sample-rate pulse (once per period)
//   i_cyc_num             flashspi read cycle: 0..2 = voice, 3 = unused
//   o_addr                flash read address for voice i_cyc_num (comb)
//   i_data, i_data_stb    flash read data and its strobe for voice i_cyc_num
//   i_wrt_ack             flashspi write override: playback frozen
//   i_cfg_*               per-voice config write (start/len/inc/loop)
//   i_trig, i_stop        per-voice start / stop pulses (stop wins)
//   o_active              per-voice FSM state (1 = PLAY)
//   o_samp0..2            voice sample outputs
//   o_samp_valid          one-cycle pulse aligned with a sample update
//
// Handshake: there is no back-pressure anywhere. i_data_stb and o_samp_valid
// are single-cycle qualifiers; the data they qualify is only meaningful in
// the cycle the strobe is high, and the receiver must accept it then.
// ---------------------------------------------------------------------------
module flash_voice3 #(
    parameter int ASZ = 24,
    parameter int DSZ = 16,
    parameter int FSZ = 8
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_samp_ena,
    input  logic [1:0]     i_cyc_num,
    output logic [ASZ-1:0] o_addr,
    input  logic [DSZ-1:0] i_data,
    input  logic           i_data_stb,
    input  logic           i_wrt_ack,
    input  logic           i_cfg_we,
    input  logic [1:0]     i_cfg_voice,
    input  logic [ASZ-1:0] i_cfg_start,
    input  logic [ASZ-1:0] i_cfg_len,
    input  logic [15:0]    i_cfg_inc,
    input  logic           i_cfg_loop,
    input  logic [2:0]     i_trig,
    input  logic [2:0]     i_stop,
    output logic [2:0]     o_active,
    output logic [DSZ-1:0] o_samp0,
    output logic [DSZ-1:0] o_samp1,
    output logic [DSZ-1:0] o_samp2,
    output logic           o_samp_valid
);

    localparam int PW = ASZ + FSZ;   // phase width: integer.fraction

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    // Per-voice configuration
    logic [ASZ-1:0] r_start [3];
    logic [ASZ-1:0] r_len   [3];
    logic [15:0]    r_inc   [3];
    logic           r_loop  [3];

    // Per-voice playback state
    state_t         r_state [3];
    logic [PW-1:0]  r_pos   [3];

    // Sample path
    logic [DSZ-1:0] r_shadow [3];
    logic [DSZ-1:0] r_samp   [3];
    logic           r_samp_valid;

    // Next-state terms
    state_t         w_state_nxt [3];
    logic [PW-1:0]  w_pos_nxt   [3];
    logic [PW:0]    w_np        [3];   // one extra bit so the end test never wraps
    logic [PW-1:0]  w_len_fx    [3];
    logic [PW-1:0]  w_wrap      [3];
    logic [2:0]     w_active;
    logic [ASZ-1:0] w_addr;
    logic           w_adv;

    // Advancing and output update share one qualifier: frozen during override.
    assign w_adv = i_samp_ena & ~i_wrt_ack;

    // -----------------------------------------------------------------------
    // FSM process 1: state register (also holds the phase accumulator)
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int v = 0; v < 3; v++) begin
                r_state[v] <= ST_IDLE;
                r_pos[v]   <= '0;
            end
        end else begin
            for (int v = 0; v < 3; v++) begin
                r_state[v] <= w_state_nxt[v];
                r_pos[v]   <= w_pos_nxt[v];
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 2: next state. Priority per voice: stop, trig, advance.
    // A trig on the samp_ena cycle therefore restarts at 0 without stepping.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int v = 0; v < 3; v++) begin
            w_np[v]        = {1'b0, r_pos[v]} + {{(PW+1-16){1'b0}}, r_inc[v]};
            w_len_fx[v]    = {r_len[v], {FSZ{1'b0}}};
            // Subtracting len in fixed point keeps the fractional phase on loop.
            w_wrap[v]      = w_np[v][PW-1:0] - w_len_fx[v];
            w_state_nxt[v] = r_state[v];
            w_pos_nxt[v]   = r_pos[v];
            if (i_stop[v]) begin
                w_state_nxt[v] = ST_IDLE;
                w_pos_nxt[v]   = '0;
            end else if (i_trig[v]) begin
                w_state_nxt[v] = ST_PLAY;
                w_pos_nxt[v]   = '0;
            end else if (w_adv && (r_state[v] == ST_PLAY)) begin
                // np_int < len is the same as np < len with zero fraction;
                // len == 0 always lands in the end-of-region branches.
                if (w_np[v] < {1'b0, w_len_fx[v]}) begin
                    w_pos_nxt[v] = w_np[v][PW-1:0];
                end else if (r_loop[v]) begin
                    w_pos_nxt[v] = w_wrap[v];
                end else begin
                    w_state_nxt[v] = ST_IDLE;
                    w_pos_nxt[v]   = '0;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 3: outputs. o_active is the exposed FSM state.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int v = 0; v < 3; v++) begin
            w_active[v] = (r_state[v] == ST_PLAY);
        end
    end

    assign o_active = w_active;

    // Configuration writes leave position and state untouched.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int v = 0; v < 3; v++) begin
                r_start[v] <= '0;
                r_len[v]   <= '0;
                r_inc[v]   <= '0;
                r_loop[v]  <= 1'b0;
            end
        end else begin
            for (int v = 0; v < 3; v++) begin
                if (i_cfg_we && (i_cfg_voice == 2'(v))) begin
                    r_start[v] <= i_cfg_start;
                    r_len[v]   <= i_cfg_len;
                    r_inc[v]   <= i_cfg_inc;
                    r_loop[v]  <= i_cfg_loop;
                end
            end
        end
    end

    // Capture into shadows during the period; publish all three at samp_ena.
    // An idle voice captures 0 so its output drains to silence.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int v = 0; v < 3; v++) begin
                r_shadow[v] <= '0;
                r_samp[v]   <= '0;
            end
            r_samp_valid <= 1'b0;
        end else begin
            for (int v = 0; v < 3; v++) begin
                if (i_data_stb && (i_cyc_num == 2'(v))) begin
                    r_shadow[v] <= w_active[v] ? i_data : '0;
                end
                if (w_adv) begin
                    r_samp[v] <= r_shadow[v];
                end
            end
            r_samp_valid <= w_adv;
        end
    end

    // Address is combinational so it settles before flashspi starts cycle 0.
    always_comb begin
        w_addr = '0;
        case (i_cyc_num)
            2'd0:    w_addr = r_start[0] + r_pos[0][PW-1:FSZ];
            2'd1:    w_addr = r_start[1] + r_pos[1][PW-1:FSZ];
            2'd2:    w_addr = r_start[2] + r_pos[2][PW-1:FSZ];
            default: w_addr = '0;
        endcase
    end

    assign o_addr       = w_addr;
    assign o_samp0      = r_samp[0];
    assign o_samp1      = r_samp[1];
    assign o_samp2      = r_samp[2];
    assign o_samp_valid = r_samp_valid;

endmodule

// File: tb/tb_flash_voice3.sv
// ---------------------------------------------------------------------------
// Bench for flash_voice3: directed table of per-period expectations, a few
// hand-written multi-cycle sequences, then randomized periods checked against
// an arithmetic reference model of the voices.
// ---------------------------------------------------------------------------
module tb_flash_voice3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        samp_ena;
    logic [1:0]  cyc_num;
    logic [23:0] addr;
    logic [15:0] data;
    logic        data_stb;
    logic        wrt_ack;
    logic        cfg_we;
    logic [1:0]  cfg_voice;
    logic [23:0] cfg_start;
    logic [23:0] cfg_len;
    logic [15:0] cfg_inc;
    logic        cfg_loop;
    logic [2:0]  trig;
    logic [2:0]  stop;
    logic [2:0]  active;
    logic [15:0] samp0, samp1, samp2;
    logic        samp_valid;

    flash_voice3 dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_samp_ena   (samp_ena),
        .i_cyc_num    (cyc_num),
        .o_addr       (addr),
        .i_data       (data),
        .i_data_stb   (data_stb),
        .i_wrt_ack    (wrt_ack),
        .i_cfg_we     (cfg_we),
        .i_cfg_voice  (cfg_voice),
        .i_cfg_start  (cfg_start),
        .i_cfg_len    (cfg_len),
        .i_cfg_inc    (cfg_inc),
        .i_cfg_loop   (cfg_loop),
        .i_trig       (trig),
        .i_stop       (stop),
        .o_active     (active),
        .o_samp0      (samp0),
        .o_samp1      (samp1),
        .o_samp2      (samp2),
        .o_samp_valid (samp_valid)
    );

    // ---------------- reference model ----------------
    int unsigned     m_start [3];
    int unsigned     m_len   [3];
    int unsigned     m_inc   [3];
    bit              m_loop  [3];
    longint unsigned m_pos   [3];   // phase in 1/256 sample units
    bit [2:0]        m_act;
    logic [15:0]     m_shadow [3];
    logic [15:0]     m_samp   [3];
    bit              m_valid;
    logic [47:0]     exp_q [$];     // expected {samp2,samp1,samp0} per valid pulse

    int n_checks = 0;
    int n_fail   = 0;
    bit rnd_mode = 1'b0;

    // values observed during the last period
    logic [23:0] got_addr [3];
    logic [2:0]  got_act;
    logic [15:0] got_samp [3];
    logic        got_valid;

    function automatic void model_reset();
        for (int v = 0; v < 3; v++) begin
            m_start[v] = 0; m_len[v] = 0; m_inc[v] = 0; m_loop[v] = 0;
            m_pos[v] = 0; m_shadow[v] = '0; m_samp[v] = '0;
        end
        m_act   = '0;
        m_valid = 1'b0;
        exp_q.delete();
    endfunction

    function automatic logic [23:0] model_addr(input logic [1:0] c);
        longint unsigned s;
        if (c == 2'd3) return 24'd0;
        s = longint'(m_start[c]) + (m_pos[c] / 256);
        return s[23:0];
    endfunction

    // Applies one rising edge worth of behaviour, reading only bench inputs.
    function automatic void model_clock();
        bit adv;
        longint unsigned np;
        if (rst) begin
            model_reset();
            return;
        end
        adv = samp_ena && !wrt_ack;
        if (adv) begin
            for (int v = 0; v < 3; v++) m_samp[v] = m_shadow[v];
            exp_q.push_back({m_shadow[2], m_shadow[1], m_shadow[0]});
        end
        m_valid = adv;
        if (data_stb && cyc_num != 2'd3)
            m_shadow[cyc_num] = m_act[cyc_num] ? data : 16'd0;
        for (int v = 0; v < 3; v++) begin
            if (stop[v]) begin
                m_act[v] = 0; m_pos[v] = 0;
            end else if (trig[v]) begin
                m_act[v] = 1; m_pos[v] = 0;
            end else if (adv && m_act[v]) begin
                np = m_pos[v] + m_inc[v];
                if (np / 256 < m_len[v])  m_pos[v] = np;
                else if (m_loop[v])       m_pos[v] = (np - longint'(m_len[v]) * 256) & 64'hFFFF_FFFF;
                else begin m_act[v] = 0; m_pos[v] = 0; end
            end
        end
        if (cfg_we && cfg_voice != 2'd3) begin
            m_start[cfg_voice] = cfg_start;
            m_len[cfg_voice]   = cfg_len;
            m_inc[cfg_voice]   = cfg_inc;
            m_loop[cfg_voice]  = cfg_loop;
        end
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [47:0] e;
        #1;
        chk("addr", addr, model_addr(cyc_num));
        chk("active", active, m_act);
        chk("samp0", samp0, m_samp[0]);
        chk("samp1", samp1, m_samp[1]);
        chk("samp2", samp2, m_samp[2]);
        chk("samp_valid", samp_valid, m_valid);
        if (samp_valid) begin
            chk("samp_stream_avail", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("samp_stream", {samp2, samp1, samp0}, e);
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        model_reset();
        check_all(); tick();
        check_all(); tick();
        rst = 1'b0;
        check_all(); tick();
    endtask

    task automatic cfg_write(input logic [1:0] v, input logic [23:0] s, input logic [23:0] l,
                             input logic [15:0] inc, input logic lp);
        cfg_we = 1'b1; cfg_voice = v; cfg_start = s; cfg_len = l; cfg_inc = inc; cfg_loop = lp;
        check_all(); tick();
        cfg_we = 1'b0;
    endtask

    // One sample period: samp_ena, a trig/stop slot, three fetches, idle tail.
    task automatic period(input logic [2:0] te, input logic [2:0] tm, input logic [2:0] sm);
        logic [23:0] a;
        samp_ena = 1'b1; trig = te; stop = '0; cyc_num = 2'd3; data_stb = 1'b0;
        check_all(); tick();
        samp_ena = 1'b0; trig = tm; stop = sm;
        check_all();
        got_samp[0] = samp0; got_samp[1] = samp1; got_samp[2] = samp2; got_valid = samp_valid;
        tick();
        trig = '0; stop = '0;
        for (int c = 0; c < 3; c++) begin
            cyc_num = 2'(c);
            a = model_addr(cyc_num);
            data = rnd_mode ? 16'($urandom) : a[15:0] + 16'(16'h1000 * (c + 1));
            data_stb = !wrt_ack;
            check_all();
            got_addr[c] = addr; got_act = active;
            tick();
        end
        data_stb = 1'b0; cyc_num = 2'd3;
        if (rnd_mode && $urandom_range(0, 3) == 0) begin
            cfg_we    = 1'b1;
            cfg_voice = 2'($urandom_range(0, 3));
            cfg_start = 24'($urandom);
            cfg_len   = 24'($urandom_range(0, 6));
            cfg_inc   = 16'($urandom_range(0, 16'h300));
            cfg_loop  = 1'($urandom_range(0, 1));
        end
        check_all(); tick();
        cfg_we = 1'b0;
        check_all(); tick();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int          voice;
        logic [2:0]  trig_mid;
        logic [23:0] exp_addr;
        logic [2:0]  exp_active;
        logic [15:0] exp_samp;
    } vec_t;

    vec_t tab [11];

    logic [23:0] frozen_addr;
    logic [15:0] held_samp0;

    initial begin
        // voice 1 one-shot, len 4, inc 1.0; loopback data = addr[15:0] + 0x2000
        tab[0]  = '{1, 3'b010, 24'h02BEEF, 3'b010, 16'h0000};
        tab[1]  = '{1, 3'b000, 24'h02BEF0, 3'b010, 16'hDEEF};
        tab[2]  = '{1, 3'b000, 24'h02BEF1, 3'b010, 16'hDEF0};
        tab[3]  = '{1, 3'b000, 24'h02BEF2, 3'b010, 16'hDEF1};
        tab[4]  = '{1, 3'b000, 24'h02BEEF, 3'b000, 16'hDEF2};
        tab[5]  = '{1, 3'b000, 24'h02BEEF, 3'b000, 16'h0000};
        // voice 0 looping, len 3, inc 1.5; loopback data = addr[15:0] + 0x1000
        tab[6]  = '{0, 3'b001, 24'h001000, 3'b001, 16'h0000};
        tab[7]  = '{0, 3'b000, 24'h001001, 3'b001, 16'h2000};
        tab[8]  = '{0, 3'b000, 24'h001000, 3'b001, 16'h2001};
        tab[9]  = '{0, 3'b000, 24'h001001, 3'b001, 16'h2000};
        tab[10] = '{0, 3'b000, 24'h001000, 3'b001, 16'h2001};

        samp_ena = 0; cyc_num = 0; data = 0; data_stb = 0; wrt_ack = 0;
        cfg_we = 0; cfg_voice = 0; cfg_start = 0; cfg_len = 0; cfg_inc = 0; cfg_loop = 0;
        trig = 0; stop = 0;

        // reset state
        reset_dut();
        cyc_num = 2'd0; #1;
        chk("rst_addr0", addr, 24'd0);
        chk("rst_active", active, 3'd0);
        chk("rst_valid", samp_valid, 1'b0);
        cyc_num = 2'd3; check_all();
        chk("cyc3_addr", addr, 24'd0);

        // table-driven periods
        cfg_write(2'd1, 24'h02BEEF, 24'd4, 16'h0100, 1'b0);
        for (int i = 0; i < 11; i++) begin
            if (i == 6) cfg_write(2'd0, 24'h001000, 24'd3, 16'h0180, 1'b1);
            period(3'b000, tab[i].trig_mid, 3'b000);
            chk("tab_addr", got_addr[tab[i].voice], tab[i].exp_addr);
            chk("tab_active", got_act, tab[i].exp_active);
            chk("tab_samp", got_samp[tab[i].voice], tab[i].exp_samp);
        end

        // trig coincident with samp_ena: restart at 0, no step that period
        cfg_write(2'd2, 24'h300000, 24'd10, 16'h0100, 1'b0);
        period(3'b100, 3'b000, 3'b000);
        chk("trig_ena_addr", got_addr[2], 24'h300000);
        chk("trig_ena_active", got_act[2], 1'b1);
        period(3'b000, 3'b000, 3'b000);
        chk("trig_ena_next", got_addr[2], 24'h300001);
        period(3'b000, 3'b000, 3'b100);
        chk("stop_active", got_act[2], 1'b0);
        period(3'b000, 3'b100, 3'b100);
        chk("trig_stop_active", got_act[2], 1'b0);

        // write override freezes playback for 40 periods
        frozen_addr = model_addr(2'd0);
        held_samp0  = m_samp[0];
        wrt_ack = 1'b1;
        for (int p = 0; p < 40; p++) begin
            period(3'b000, 3'b000, 3'b000);
            chk("freeze_addr", got_addr[0], frozen_addr);
            chk("freeze_samp0", got_samp[0], held_samp0);
            chk("freeze_valid", got_valid, 1'b0);
        end
        wrt_ack = 1'b0;
        period(3'b000, 3'b000, 3'b000);
        chk("resume_valid", got_valid, 1'b1);

        // inc rewritten mid-play: no jump at the write, next step uses new inc
        reset_dut();
        cfg_write(2'd0, 24'h000000, 24'd100, 16'h0100, 1'b0);
        period(3'b000, 3'b001, 3'b000);
        chk("incw_addr0", got_addr[0], 24'd0);
        period(3'b000, 3'b000, 3'b000);
        chk("incw_addr1", got_addr[0], 24'd1);
        cyc_num = 2'd0;
        cfg_write(2'd0, 24'h000000, 24'd100, 16'h0200, 1'b0);
        chk("incw_nojump", addr, 24'd1);
        period(3'b000, 3'b000, 3'b000);
        chk("incw_step2", got_addr[0], 24'd3);

        // asynchronous reset between edges clears immediately
        period(3'b000, 3'b000, 3'b000);
        #1; rst = 1'b1; model_reset();
        #1;
        chk("arst_active", active, 3'd0);
        chk("arst_samp0", samp0, 16'd0);
        chk("arst_valid", samp_valid, 1'b0);
        tick(); tick();
        rst = 1'b0;
        check_all(); tick();

        // randomized periods against the model
        rnd_mode = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [2:0] te, tm, sm;
            wrt_ack = ($urandom_range(0, 9) == 0);
            te = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            tm = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            sm = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            period(te, tm, sm);
        end
        wrt_ack = 1'b0;
        chk("exp_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
